// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state and grant encodings,
// default widths and a small helper for the round-robin pick.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  function automatic grant_t other_port(input grant_t g);
    return (g == GNT_F) ? GNT_D : GNT_F;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the arbiter: fetch port F (read-only) and data port D.
// master = the requesters (CPU side), slave = the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_ack;
  logic [DATA_WIDTH-1:0] f_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
    input  f_ack, f_rdata, d_ack, d_rdata
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
    output f_ack, f_rdata, d_ack, d_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. Bit 0 of i_req is port F, bit 1 is port D;
// on a conflict the port that did not win last time is chosen.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  grant_t     i_last,
  output grant_t     o_gnt,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_gnt   = GNT_F;
    if (i_req == 2'b11) begin
      o_gnt = other_port(i_last);
    end else if (i_req[1]) begin
      o_gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-port synchronous memory:
// IDLE picks a winner and latches its request, ISSUE drives the memory, DONE captures and acks.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  mem_arbiter_if.slave          bus,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  state_t                r_state;
  grant_t                r_grant;
  grant_t                r_last;
  logic                  r_lat_we;
  logic [ADDR_WIDTH-1:0] r_lat_addr;
  logic [DATA_WIDTH-1:0] r_lat_wdata;
  logic                  r_f_ack;
  logic                  r_d_ack;
  logic [DATA_WIDTH-1:0] r_f_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic [1:0]            w_elig;
  grant_t                w_gnt;
  logic                  w_valid;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_we;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // A port whose ack is showing this cycle has just been served and must not be re-granted.
  assign w_elig = {bus.d_req & ~r_d_ack, bus.f_req & ~r_f_ack};

  rr_arb2 u_rr_arb2 (
    .i_req   (w_elig),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  // Fetches never write, and leave the previous write data on the bus untouched.
  assign w_sel_addr  = (w_gnt == GNT_D) ? bus.d_addr : bus.f_addr;
  assign w_sel_we    = (w_gnt == GNT_D) & bus.d_we;
  assign w_sel_wdata = (w_gnt == GNT_D) ? bus.d_wdata : r_lat_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= GNT_F;
      r_last      <= GNT_D;
      r_lat_we    <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_f_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_grant     <= w_gnt;
            r_last      <= w_gnt;
            r_lat_addr  <= w_sel_addr;
            r_lat_we    <= w_sel_we;
            r_lat_wdata <= w_sel_wdata;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The memory has sampled the write on this edge; address stays put for DONE.
          r_lat_we <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (r_grant == GNT_F) begin
            r_f_rdata <= mem_out;
            r_f_ack   <= 1'b1;
          end else begin
            r_d_rdata <= mem_out;
            r_d_ack   <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_lat_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.f_ack   = r_f_ack;
  assign bus.d_ack   = r_d_ack;
  assign bus.f_rdata = r_f_rdata;
  assign bus.d_rdata = r_d_rdata;

  assign busy     = (r_state != S_IDLE);
  assign mem_we   = r_lat_we;
  assign mem_addr = r_lat_addr;
  assign mem_data = r_lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-first single-port memory model:
// a table of single transactions plus hand-written conflict, hold and reset sequences.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_out  (mem_out)
  );

  // Write-first single-port memory with one-cycle registered read.
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[8]  = 16'h7100;
    mem[9]  = 16'h8100;
    mem_out = '0;
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[mem_addr] <= mem_data;
        mem_out       <= mem_data;
        we_cnt        = we_cnt + 1;
      end else begin
        mem_out <= mem[mem_addr];
      end
    end
  end

  // Acks must never overlap.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      checks = checks + 1;
      if (bus.f_ack && bus.d_ack) begin
        errors = errors + 1;
        $display("FAIL ack_overlap: f_ack=%0b d_ack=%0b required not both 1 at %0t",
                 bus.f_ack, bus.d_ack, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  typedef struct {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          exp_port;   // 0 = F acks, 1 = D acks
    logic [DW-1:0] exp_rdata;
    int            exp_we;     // mem_we cycles this access must produce
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int we0;
    logic got;
    we0 = we_cnt;
    bus.f_req   = v.f_req;
    bus.f_addr  = v.f_addr;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      tick();
      cyc++;
      if (bus.f_ack || bus.d_ack) got = 1'b1;
    end
    chk($sformatf("v%0d_ack_seen", idx), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d_latency", idx), cyc, 32'd3);
    chk($sformatf("v%0d_port", idx), {31'd0, bus.d_ack}, {31'd0, v.exp_port});
    if (v.exp_port)
      chk($sformatf("v%0d_d_rdata", idx), {16'd0, bus.d_rdata}, {16'd0, v.exp_rdata});
    else
      chk($sformatf("v%0d_f_rdata", idx), {16'd0, bus.f_rdata}, {16'd0, v.exp_rdata});
    chk($sformatf("v%0d_we_cycles", idx), we_cnt - we0, v.exp_we);
    idle_inputs();
    tick();
    chk($sformatf("v%0d_ack_width", idx), {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
    chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int f_cyc, d_cyc, n;
    logic [DW-1:0] f_val, d_val;
    logic          ev_port [8];
    int            ev_cyc  [8];
    logic [DW-1:0] ev_data [8];

    vecs[0] = '{1'b1, 6'd8,  1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h7100, 0};
    vecs[1] = '{1'b0, 6'd0,  1'b1, 1'b1, 6'd20, 16'hBEEF, 1'b1, 16'hBEEF, 1};
    vecs[2] = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd20, 16'h0000, 1'b1, 16'hBEEF, 0};
    vecs[3] = '{1'b1, 6'd20, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 16'hBEEF, 0};
    vecs[4] = '{1'b0, 6'd0,  1'b1, 1'b1, 6'd30, 16'h0A5A, 1'b1, 16'h0A5A, 1};
    vecs[5] = '{1'b1, 6'd30, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h0A5A, 0};
    vecs[6] = '{1'b0, 6'd0,  1'b1, 1'b0, 6'd8,  16'h0000, 1'b1, 16'h7100, 0};

    idle_inputs();
    #1 rst_n = 1'b0;
    #3;
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_mem_we",  {31'd0, mem_we}, 32'd0);
    chk("rst_acks",    {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
    chk("rst_f_rdata", {16'd0, bus.f_rdata}, 32'd0);
    chk("rst_d_rdata", {16'd0, bus.d_rdata}, 32'd0);
    chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Conflict straight after reset: F must win first.
    bus.f_req = 1'b1; bus.f_addr = 6'd8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd9;
    f_cyc = 0; d_cyc = 0; f_val = '0; d_val = '0;
    for (int c = 1; c <= 15 && (f_cyc == 0 || d_cyc == 0); c++) begin
      tick();
      if (bus.f_ack) begin f_cyc = c; f_val = bus.f_rdata; bus.f_req = 1'b0; end
      if (bus.d_ack) begin d_cyc = c; d_val = bus.d_rdata; bus.d_req = 1'b0; end
    end
    idle_inputs();
    chk("conf_f_cycle", f_cyc, 32'd3);
    chk("conf_f_rdata", {16'd0, f_val}, 32'h7100);
    chk("conf_d_cycle", d_cyc, 32'd6);
    chk("conf_d_rdata", {16'd0, d_val}, 32'h8100);
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Both held for 12 cycles after a D grant: F,D,F,D one ack every 3 cycles.
    bus.f_req = 1'b1; bus.f_addr = 6'd8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd9;
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((bus.f_ack || bus.d_ack) && n < 8) begin
        ev_port[n] = bus.d_ack;
        ev_cyc[n]  = c;
        ev_data[n] = bus.d_ack ? bus.d_rdata : bus.f_rdata;
        n++;
      end
    end
    idle_inputs();
    chk("rr_ack_count", n, 32'd4);
    for (int k = 0; k < 4 && k < n; k++) begin
      chk($sformatf("rr_port%0d", k), {31'd0, ev_port[k]}, {31'd0, logic'(k % 2)});
      chk($sformatf("rr_cycle%0d", k), ev_cyc[k], 3 * (k + 1));
      chk($sformatf("rr_data%0d", k), {16'd0, ev_data[k]}, (k % 2) ? 32'h8100 : 32'h7100);
    end
    tick();
    chk("rr_idle_busy", {31'd0, busy}, 32'd0);

    // F held after its ack: no re-grant in the ack cycle, next ack after a fresh 3-cycle access.
    bus.f_req = 1'b1; bus.f_addr = 6'd9;
    f_cyc = 0; d_cyc = 0;
    for (int c = 1; c <= 15 && d_cyc == 0; c++) begin
      tick();
      if (f_cyc != 0 && c == f_cyc + 1)
        chk("hold_no_regrant_busy", {31'd0, busy}, 32'd0);
      if (bus.f_ack) begin
        if (f_cyc == 0) f_cyc = c;
        else begin d_cyc = c; f_val = bus.f_rdata; end
      end
    end
    idle_inputs();
    chk("hold_first_ack", f_cyc, 32'd3);
    chk("hold_second_ack", d_cyc, 32'd7);
    chk("hold_f_rdata", {16'd0, f_val}, 32'h8100);
    tick();
    tick();

    // Asynchronous reset in the middle of a write's ISSUE cycle.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd21; bus.d_wdata = 16'h1234;
    tick();
    chk("rst5_issue_we", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst5_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst5_busy",   {31'd0, busy}, 32'd0);
    chk("rst5_acks",   {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
    chk("rst5_f_rdata", {16'd0, bus.f_rdata}, 32'd0);
    chk("rst5_d_rdata", {16'd0, bus.d_rdata}, 32'd0);
    idle_inputs();
    tick();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    chk("rst5_idle_busy", {31'd0, busy}, 32'd0);
    chk("rst5_idle_we",   {31'd0, mem_we}, 32'd0);
    chk("rst5_mem21",     {16'd0, mem[21]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
